instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encoder counterpart of the 9-bit control decoder: accepts decoded-intent instruction descriptors over a valid/ready stream.
- Packs each descriptor into a 9-bit machine word and writes it to sequential addresses of the instruction memory write port.
- Used by the testbench and boot path to load programs before the processor runs.
- Validates each descriptor, counts words and reports done or error.

Parameters:
DEPTH, 256, instruction memory depth in words; 2 <= DEPTH <= 2**AW
AW, 8, address width; clog2(DEPTH)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; clears counters and enters LOAD
in_valid  in  1  descriptor valid
in_ready  out  1  encoder can accept a descriptor
in_kind  in  2  00 ALU, 01 LOAD, 10 STORE, 11 BRANCH
in_alu_op  in  3  ALU operation code; ALU kind only
in_uncond  in  1  branch unconditional (1) or branch-if-zero (0)
in_how_high  in  2  branch distance class
in_field  in  6  operand field; BRANCH uses [2:0] only
in_last  in  1  descriptor is the final word of the program
im_we  out  1  instruction memory write enable
im_addr  out  AW  write address
im_wdata  out  9  encoded machine word
busy  out  1  state == LOAD
done  out  1  state == DONE
err  out  1  state == ERR
err_code  out  2  00 none, 01 illegal descriptor, 10 overflow
word_count  out  AW+1  words written since the last start

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state IDLE; im_we 0; im_addr 0; im_wdata 0; word_count 0; err_code 00; busy, done, err 0; in_ready 0.
- States: IDLE, LOAD, DONE, ERR.
  - IDLE -> LOAD on start.
  - DONE/ERR -> LOAD on start.
  - start in LOAD aborts the load: counters clear, state stays LOAD, and any descriptor presented that same cycle is ignored.
- Handshake:
  - in_ready = (state == LOAD) && !start.
  - Transfer occurs when in_valid && in_ready.
  - in_ready does not depend on in_valid.
  - Back-to-back transfers every cycle are allowed.
- Encoding, bits [8:0]:
  - ALU: {in_alu_op, in_field}. Illegal if in_alu_op > 3'b100.
  - LOAD: {3'b101, in_field}.
  - STORE: {3'b110, in_field}.
  - BRANCH: {3'b111, in_uncond, in_how_high, in_field[2:0]}. Illegal if in_field[5:3] != 0.
  - ALU/LOAD/STORE: illegal if in_uncond != 0 or in_how_high != 0.
- Latency: a legal transfer in cycle N produces, registered in cycle N+1:
  - im_we = 1
  - im_addr = word_count value sampled at N (low AW bits)
  - im_wdata = encoded word
  - word_count increments in N+1
  - im_we is 0 in every other cycle.
- Illegal transfer in cycle N:
  - No write.
  - N+1: state ERR, err_code 01, word_count unchanged.
- Legal transfer with in_last in cycle N: write proceeds; N+1: state DONE.
- Overflow: a legal transfer at address DEPTH-1 without in_last is written; N+1: state ERR, err_code 10.
  - Priority: in_last at DEPTH-1 wins, giving DONE with no error.
- err_code holds until start or reset; start clears it to 00.
- in_valid outside LOAD is ignored: no write, no error.
- Reset asserted mid-load: all outputs return to reset values next edge. A pending write is dropped, and im_we is 0 in the cycle after reset.

Optional Feature:
- Macro: INSTR_CKSUM_EN.
- When defined:
  - Extra output port cksum, 9 bits, reset 0, cleared on start.
  - On each cycle with im_we = 1: cksum <= cksum XOR im_wdata, updated the same edge as word_count.
- When undefined: port absent; no checksum logic.

Test Plan:
- Reset, start, send ALU op=000 field=6'h0A with in_last -> next cycle im_we=1, im_addr=0, im_wdata=9'h00A; following cycle done=1, word_count=1.
- Back-to-back: LOAD field=6'h05, STORE field=6'h11, BRANCH uncond=1 how_high=2 field=3'b011 last -> writes at addr 0,1,2 of 9'h145, 9'h191, 9'h1F3; done=1, word_count=3.
- Illegal: ALU op=3'b110 as 2nd word -> only addr 0 written; err=1, err_code=01, word_count=1, in_ready=0; then start -> busy=1, err_code=00, word_count=0.
- Overflow with DEPTH=4: 4 legal words without last -> addrs 0..3 written; err=1, err_code=10. Repeat with last on 4th word -> done=1, err=0.
- Reset on the cycle after a transfer -> im_we=0, word_count=0, state IDLE. Start during LOAD with in_valid=1 -> no write, word_count=0.
- INSTR_CKSUM_EN: words 9'h00A, 9'h145 -> cksum=9'h14F; start -> cksum=0.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Packs decoded-intent instruction descriptors into 9-bit machine words and
//   writes them to consecutive instruction-memory addresses. Used to load a
//   program before the processor runs. Each descriptor is validated. The block
//   counts the words written and reports done or error.
//
// Optional build macro: INSTR_CKSUM_EN adds a running XOR checksum output.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   start           one-cycle pulse: clear counters/error and enter LOAD
//   in_valid/ready  descriptor stream handshake (ready = LOAD && !start)
//   in_kind         00 ALU, 01 LOAD, 10 STORE, 11 BRANCH
//   in_alu_op       ALU op code (ALU only, 0..4 legal)
//   in_uncond       branch unconditional flag (BRANCH only)
//   in_how_high     branch distance class (BRANCH only)
//   in_field        operand field; BRANCH uses [2:0]
//   in_last         descriptor is the final program word
//   im_we/addr/wdata instruction memory write port (registered)
//   busy/done/err   state is LOAD / DONE / ERR
//   err_code        00 none, 01 illegal descriptor, 10 overflow
//   word_count      words written since the last start
//   cksum           (INSTR_CKSUM_EN only) XOR of all words written
module instr_encoder_loader #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_kind,
  input  logic [2:0]    in_alu_op,
  input  logic          in_uncond,
  input  logic [1:0]    in_how_high,
  input  logic [5:0]    in_field,
  input  logic          in_last,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [8:0]    im_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW:0]   word_count
`ifdef INSTR_CKSUM_EN
  ,
  output logic [8:0]    cksum
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

  localparam logic [1:0] KindAlu   = 2'b00;
  localparam logic [1:0] KindLoad  = 2'b01;
  localparam logic [1:0] KindStore = 2'b10;
  localparam logic [1:0] KindBr    = 2'b11;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrIllegal = 2'b01;
  localparam logic [1:0] ErrOverflow = 2'b10;

  // Count value at which the write lands on the last memory word.
  localparam logic [AW:0] LastWord = (AW + 1)'(DEPTH - 1);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [8:0]    wdata_q, wdata_d;
  logic [1:0]    code_q, code_d;
  logic [AW:0]   count_q, count_d;
  logic [8:0]    cksum_q, cksum_d;

  logic [8:0] enc;
  logic       legal;
  logic       xfer;

  // Descriptor encoding and legality.
  always_comb begin
    enc   = 9'h000;
    legal = 1'b0;
    unique case (in_kind)
      KindAlu: begin
        enc   = {in_alu_op, in_field};
        legal = (in_alu_op <= 3'b100) && !in_uncond && (in_how_high == 2'b00);
      end
      KindLoad: begin
        enc   = {3'b101, in_field};
        legal = !in_uncond && (in_how_high == 2'b00);
      end
      KindStore: begin
        enc   = {3'b110, in_field};
        legal = !in_uncond && (in_how_high == 2'b00);
      end
      KindBr: begin
        enc   = {3'b111, in_uncond, in_how_high, in_field[2:0]};
        legal = (in_field[5:3] == 3'b000);
      end
      default: ;
    endcase
  end

  assign in_ready = (state_q == StLoad) && !start;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    code_d  = code_q;
    count_d = count_q;
    cksum_d = cksum_q;
    if (start) begin
      // Valid from any state; a descriptor offered this cycle is ignored
      // because in_ready is held low.
      state_d = StLoad;
      code_d  = ErrNone;
      count_d = '0;
      cksum_d = 9'h000;
    end else if (xfer) begin
      if (!legal) begin
        state_d = StErr;
        code_d  = ErrIllegal;
      end else begin
        we_d    = 1'b1;
        addr_d  = count_q[AW-1:0];
        wdata_d = enc;
        count_d = count_q + (AW + 1)'(1);
        cksum_d = cksum_q ^ enc;
        // in_last takes priority over overflow on the final word.
        if (in_last) begin
          state_d = StDone;
        end else if (count_q == LastWord) begin
          state_d = StErr;
          code_d  = ErrOverflow;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 9'h000;
      code_q  <= ErrNone;
      count_q <= '0;
      cksum_q <= 9'h000;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      code_q  <= code_d;
      count_q <= count_d;
      cksum_q <= cksum_d;
    end
  end

  assign im_we      = we_q;
  assign im_addr    = addr_q;
  assign im_wdata   = wdata_q;
  assign err_code   = code_q;
  assign word_count = count_q;
  assign busy       = (state_q == StLoad);
  assign done       = (state_q == StDone);
  assign err        = (state_q == StErr);

`ifdef INSTR_CKSUM_EN
  assign cksum = cksum_q;
`else
  logic unused_cksum;
  assign unused_cksum = ^cksum_q;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_kind = 2'b00;
  logic [2:0]    in_alu_op = 3'b000;
  logic          in_uncond = 1'b0;
  logic [1:0]    in_how_high = 2'b00;
  logic [5:0]    in_field = 6'h00;
  logic          in_last = 1'b0;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [8:0]    im_wdata;
  logic          busy, done, err;
  logic [1:0]    err_code;
  logic [AW:0]   word_count;
`ifdef INSTR_CKSUM_EN
  logic [8:0]    cksum;
`endif

  instr_encoder_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_alu_op(in_alu_op), .in_uncond(in_uncond),
    .in_how_high(in_how_high), .in_field(in_field), .in_last(in_last),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .word_count(word_count)
`ifdef INSTR_CKSUM_EN
    , .cksum(cksum)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 loading, 2 finished, 3 error.
  int m_mode = 0;
  int m_cnt = 0;
  int m_code = 0;
  int m_we = 0;
  int m_addr = 0;
  int m_wdata = 0;
  int m_ck = 0;

  function automatic void describe(output int word, output bit ok);
    int k, op, u, hh, f;
    k = int'(in_kind); op = int'(in_alu_op); u = int'(in_uncond);
    hh = int'(in_how_high); f = int'(in_field);
    case (k)
      0: begin word = op * 64 + f; ok = (op <= 4) && u == 0 && hh == 0; end
      1: begin word = 5 * 64 + f; ok = u == 0 && hh == 0; end
      2: begin word = 6 * 64 + f; ok = u == 0 && hh == 0; end
      default: begin word = 7 * 64 + u * 32 + hh * 8 + (f % 8); ok = (f / 8) == 0; end
    endcase
  endfunction

  always @(posedge clk) begin
    int w;
    bit ok;
    m_we = 0;
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_code = 0; m_addr = 0; m_wdata = 0; m_ck = 0;
    end else if (start) begin
      m_mode = 1; m_cnt = 0; m_code = 0; m_ck = 0;
    end else if (m_mode == 1 && in_valid) begin
      describe(w, ok);
      if (!ok) begin
        m_mode = 3; m_code = 1;
      end else begin
        m_we = 1; m_addr = m_cnt % DEPTH; m_wdata = w; m_ck = m_ck ^ w;
        if (in_last) m_mode = 2;
        else if (m_cnt == DEPTH - 1) begin m_mode = 3; m_code = 2; end
        m_cnt = m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("im_we", 32'(im_we), 32'(m_we));
      if (m_we != 0) begin
        check("im_addr", 32'(im_addr), 32'(m_addr));
        check("im_wdata", 32'(im_wdata), 32'(m_wdata));
      end
      check("word_count", 32'(word_count), 32'(m_cnt));
      check("busy", 32'(busy), 32'(m_mode == 1));
      check("done", 32'(done), 32'(m_mode == 2));
      check("err", 32'(err), 32'(m_mode == 3));
      check("err_code", 32'(err_code), 32'(m_code));
      check("in_ready", 32'(in_ready), 32'(m_mode == 1 && !start));
`ifdef INSTR_CKSUM_EN
      check("cksum", 32'(cksum), 32'(m_ck));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic setd(input logic [1:0] k, input logic [2:0] op, input logic u,
                      input logic [1:0] hh, input logic [5:0] f, input logic last);
    in_valid = 1'b1; in_kind = k; in_alu_op = op; in_uncond = u;
    in_how_high = hh; in_field = f; in_last = last;
  endtask

  task automatic do_start();
    in_valid = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    cyc();
    cyc();
    chk_en = 1'b1;
    // Reset values.
    check("rst_im_we", 32'(im_we), 0);
    check("rst_im_addr", 32'(im_addr), 0);
    check("rst_im_wdata", 32'(im_wdata), 0);
    check("rst_word_count", 32'(word_count), 0);
    check("rst_flags", {29'd0, busy, done, err}, 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    // in_valid while idle is ignored.
    reset = 1'b0;
    setd(2'b00, 3'b000, 1'b0, 2'b00, 6'h0A, 1'b1);
    cyc();
    check("idle_ignore_we", 32'(im_we), 0);
    check("idle_ignore_err", 32'(err), 0);

    // Single ALU word with last.
    do_start();
    setd(2'b00, 3'b000, 1'b0, 2'b00, 6'h0A, 1'b1);
    cyc();
    in_valid = 1'b0;
    check("t1_we", 32'(im_we), 1);
    check("t1_addr", 32'(im_addr), 0);
    check("t1_wdata", 32'(im_wdata), 32'h00A);
    cyc();
    check("t1_done", 32'(done), 1);
    check("t1_count", 32'(word_count), 1);
    // in_valid while done is ignored.
    setd(2'b01, 3'b000, 1'b0, 2'b00, 6'h01, 1'b0);
    cyc();
    check("done_ignore_we", 32'(im_we), 0);

    // Back-to-back LOAD, STORE, BRANCH.
    do_start();
    setd(2'b01, 3'b000, 1'b0, 2'b00, 6'h05, 1'b0);
    cyc();
    check("t2_w0", {23'd0, im_wdata}, 32'h145);
    check("t2_a0", 32'(im_addr), 0);
    setd(2'b10, 3'b000, 1'b0, 2'b00, 6'h11, 1'b0);
    cyc();
    check("t2_w1", {23'd0, im_wdata}, 32'h191);
    check("t2_a1", 32'(im_addr), 1);
    setd(2'b11, 3'b000, 1'b1, 2'b10, 6'h03, 1'b1);
    cyc();
    in_valid = 1'b0;
    check("t2_w2", {23'd0, im_wdata}, 32'h1F3);
    check("t2_a2", 32'(im_addr), 2);
    check("t2_done", 32'(done), 1);
    check("t2_count", 32'(word_count), 3);
    cyc();

    // Illegal ALU op as second word.
    do_start();
    setd(2'b00, 3'b001, 1'b0, 2'b00, 6'h01, 1'b0);
    cyc();
    setd(2'b00, 3'b110, 1'b0, 2'b00, 6'h02, 1'b0);
    cyc();
    in_valid = 1'b0;
    check("t3_we", 32'(im_we), 0);
    check("t3_err", 32'(err), 1);
    check("t3_code", 32'(err_code), 1);
    check("t3_count", 32'(word_count), 1);
    check("t3_ready", 32'(in_ready), 0);
    do_start();
    check("t3_busy", 32'(busy), 1);
    check("t3_code_clr", 32'(err_code), 0);
    check("t3_count_clr", 32'(word_count), 0);
    // Other illegal forms: branch with high field bits, STORE with uncond.
    setd(2'b11, 3'b000, 1'b0, 2'b00, 6'h09, 1'b0);
    cyc();
    check("t3_br_code", 32'(err_code), 1);
    do_start();
    setd(2'b10, 3'b000, 1'b1, 2'b00, 6'h04, 1'b0);
    cyc();
    check("t3_st_code", 32'(err_code), 1);

    // Overflow at DEPTH=4, then the same with last on the final word.
    do_start();
    for (int i = 0; i < 4; i++) begin
      setd(2'b00, 3'(i), 1'b0, 2'b00, 6'(i + 8), 1'b0);
      cyc();
    end
    in_valid = 1'b0;
    check("t4_addr3", 32'(im_addr), 3);
    check("t4_err", 32'(err), 1);
    check("t4_code", 32'(err_code), 2);
    check("t4_count", 32'(word_count), 4);
    do_start();
    for (int i = 0; i < 4; i++) begin
      setd(2'b01, 3'b000, 1'b0, 2'b00, 6'(i), 1'(i == 3));
      cyc();
    end
    in_valid = 1'b0;
    check("t4l_done", 32'(done), 1);
    check("t4l_err", 32'(err), 0);
    check("t4l_code", 32'(err_code), 0);

    // Reset the cycle after a transfer, and reset alongside a transfer.
    do_start();
    setd(2'b01, 3'b000, 1'b0, 2'b00, 6'h07, 1'b0);
    cyc();
    in_valid = 1'b0;
    reset = 1'b1;
    cyc();
    check("t5_we", 32'(im_we), 0);
    check("t5_count", 32'(word_count), 0);
    check("t5_idle", {29'd0, busy, done, err}, 0);
    reset = 1'b0;
    do_start();
    setd(2'b01, 3'b000, 1'b0, 2'b00, 6'h07, 1'b0);
    reset = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("t5_drop_we", 32'(im_we), 0);
    reset = 1'b0;

    // Start during LOAD with a descriptor presented.
    do_start();
    setd(2'b01, 3'b000, 1'b0, 2'b00, 6'h02, 1'b0);
    cyc();
    setd(2'b01, 3'b000, 1'b0, 2'b00, 6'h03, 1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    in_valid = 1'b0;
    check("t6_we", 32'(im_we), 0);
    check("t6_count", 32'(word_count), 0);
    check("t6_busy", 32'(busy), 1);

`ifdef INSTR_CKSUM_EN
    do_start();
    setd(2'b00, 3'b000, 1'b0, 2'b00, 6'h0A, 1'b0);
    cyc();
    setd(2'b01, 3'b000, 1'b0, 2'b00, 6'h05, 1'b1);
    cyc();
    in_valid = 1'b0;
    check("ck_val", {23'd0, cksum}, 32'h14F);
    do_start();
    check("ck_clr", {23'd0, cksum}, 0);
`endif

    cyc();
    cyc();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
